// File: rtl/rrat_retire_if.sv
// rrat_retire_if: handshake bundle between the retirement stage and its
// neighbours (ROB head / dequeue, LSQ store commit).
//   slave  modport: seen from the retirement stage (consumes ROB head, drives
//                   ROB_DQ and Store_Commit).
//   master modport: seen from the ROB/LSQ side.
interface rrat_retire_if #(
  parameter int LOG_PHYS = 6,
  parameter int LEN_UID  = 32
);
  logic                ROB_Head_Valid;
  logic                ROB_Head_Done;
  logic                ROB_Head_Exception;
  logic                ROB_Head_IsStore;
  logic [4:0]          ROB_Head_RD;
  logic [LOG_PHYS-1:0] ROB_Head_PhyRD;
  logic [LEN_UID-1:0]  ROB_Head_UID;
  logic                ROB_DQ;
  logic                Store_Commit;
  logic                Store_Commit_Ack;

  modport slave (
    input  ROB_Head_Valid, ROB_Head_Done, ROB_Head_Exception, ROB_Head_IsStore,
           ROB_Head_RD, ROB_Head_PhyRD, ROB_Head_UID, Store_Commit_Ack,
    output ROB_DQ, Store_Commit
  );

  modport master (
    output ROB_Head_Valid, ROB_Head_Done, ROB_Head_Exception, ROB_Head_IsStore,
           ROB_Head_RD, ROB_Head_PhyRD, ROB_Head_UID, Store_Commit_Ack,
    input  ROB_DQ, Store_Commit
  );
endinterface

// File: rtl/rrat_retire.sv
// rrat_retire: in-order retirement at the ROB head. Maintains the Retirement
// RAT (arch reg -> committed phys reg), frees the previously committed phys
// reg on each commit, sequences store commit with the LSQ and halts for good
// (until RESET) when an excepting instruction reaches the head.
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   rob                 ROB head / ROB_DQ / Store_Commit handshake (slave)
//   RegRecycle_OUT      1-cycle pulse, RegRecycleID_OUT is the freed phys reg
//   Retired_UID/Count   UID of last retired instr, total retired (wraps)
//   Halt_OUT            sticky exception halt
//   Query_Arch/Phys/Valid  combinational RRAT read port (pre-edge state)
module rrat_retire #(
  parameter int LOG_PHYS = 6,
  parameter int LEN_UID  = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  rrat_retire_if.slave        rob,
  output logic                RegRecycle_OUT,
  output logic [LOG_PHYS-1:0] RegRecycleID_OUT,
  output logic [LEN_UID-1:0]  Retired_UID,
  output logic [31:0]         Retired_Count,
  output logic                Halt_OUT,
  input  logic [4:0]          Query_Arch,
  output logic [LOG_PHYS-1:0] Query_Phys,
  output logic                Query_Valid
);

  typedef enum logic [1:0] {IDLE, ST_WAIT, HALT} state_t;

  state_t                         state;
  logic                           dq_q;
  logic                           st_q;
  logic [31:0]                    rrat_vld;
  logic [31:0][LOG_PHYS-1:0]      rrat_phys;
  logic                           eligible;
  logic                           do_retire;
  logic                           wr_en;

  // The ROB advances one cycle after ROB_DQ, so the head seen while ROB_DQ
  // is high is the one just retired and must not be retired again.
  assign eligible = rob.ROB_Head_Valid & rob.ROB_Head_Done & ~dq_q;

  always_comb begin
    do_retire = 1'b0;
    case (state)
      IDLE:    do_retire = eligible & ~rob.ROB_Head_Exception & ~rob.ROB_Head_IsStore;
      ST_WAIT: do_retire = rob.Store_Commit_Ack;
      default: do_retire = 1'b0;
    endcase
  end

  // r0 has no physical mapping; commits to it never touch the RRAT.
  assign wr_en = do_retire & (rob.ROB_Head_RD != 5'd0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state            <= IDLE;
      dq_q             <= 1'b0;
      st_q             <= 1'b0;
      RegRecycle_OUT   <= 1'b0;
      RegRecycleID_OUT <= '0;
      Retired_UID      <= '0;
      Retired_Count    <= '0;
      Halt_OUT         <= 1'b0;
      rrat_vld         <= '0;
    end else begin
      dq_q           <= do_retire;
      RegRecycle_OUT <= 1'b0;
      case (state)
        IDLE: begin
          if (eligible) begin
            if (rob.ROB_Head_Exception) begin
              state    <= HALT;
              Halt_OUT <= 1'b1;
            end else if (rob.ROB_Head_IsStore) begin
              state <= ST_WAIT;
              st_q  <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (rob.Store_Commit_Ack) begin
            state <= IDLE;
            st_q  <= 1'b0;
          end
        end
        default: state <= HALT;
      endcase
      if (do_retire) begin
        Retired_UID   <= rob.ROB_Head_UID;
        Retired_Count <= Retired_Count + 32'd1;
      end
      if (wr_en) begin
        rrat_vld[rob.ROB_Head_RD] <= 1'b1;
        // First commit to a register since reset has nothing to free.
        if (rrat_vld[rob.ROB_Head_RD]) begin
          RegRecycle_OUT   <= 1'b1;
          RegRecycleID_OUT <= rrat_phys[rob.ROB_Head_RD];
        end
      end
    end
  end

  // Phys fields are qualified by rrat_vld, so they need no reset.
  always_ff @(posedge CLK) begin
    if (wr_en) rrat_phys[rob.ROB_Head_RD] <= rob.ROB_Head_PhyRD;
  end

  assign rob.ROB_DQ       = dq_q;
  assign rob.Store_Commit = st_q;
  assign Query_Phys       = rrat_phys[Query_Arch];
  assign Query_Valid      = rrat_vld[Query_Arch];

endmodule

// File: doc/rrat_retire.md
Name: rrat_retire

Overview:
- Retirement stage at the head of the reorder buffer. Commits completed instructions in program order and maintains the Retirement RAT (RRAT), which maps each architectural register to its committed physical register.
- On each commit it returns the previously committed physical register of the destination to Rename through the register-recycle interface (RegRecycle/RegRecycleID).
- Sequences store commit with the load/store queue and halts retirement when an excepting instruction reaches the ROB head.

Parameters:
- LOG_PHYS, 6, physical register index width (64 physical registers)
- LEN_UID, 32, instruction unique-ID width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous reset, active-high
- ROB_Head_Valid  in  1  ROB head entry present
- ROB_Head_Done  in  1  head entry finished execution
- ROB_Head_Exception  in  1  head entry raised exception
- ROB_Head_IsStore  in  1  head entry is a store
- ROB_Head_RD  in  5  head architectural destination (0 = none)
- ROB_Head_PhyRD  in  LOG_PHYS  head physical destination
- ROB_Head_UID  in  LEN_UID  head instruction UID
- ROB_DQ  out  1  one-cycle pulse: dequeue ROB head
- Store_Commit  out  1  request to LSQ to commit head store
- Store_Commit_Ack  in  1  LSQ accepted store commit
- RegRecycle_OUT  out  1  one-cycle pulse: free RegRecycleID_OUT
- RegRecycleID_OUT  out  LOG_PHYS  physical register being freed
- Retired_UID  out  LEN_UID  UID of last retired instruction
- Retired_Count  out  32  total instructions retired
- Halt_OUT  out  1  sticky; retirement stopped on exception
- Query_Arch  in  5  RRAT read address
- Query_Phys  out  LOG_PHYS  combinational RRAT[Query_Arch].phys
- Query_Valid  out  1  combinational RRAT[Query_Arch].valid

Behaviour:
- State: RRAT of 32 entries {valid, phys[LOG_PHYS]}; FSM states IDLE, ST_WAIT, HALT.
- Reset (RESET=1 at edge):
  - All RRAT valid bits = 0; FSM = IDLE.
  - All outputs = 0: ROB_DQ, Store_Commit, RegRecycle_OUT, RegRecycleID_OUT, Retired_UID, Retired_Count, Halt_OUT.
  - Reset overrides all other activity, including in ST_WAIT (Store_Commit drops next cycle).
- All outputs except Query_* are registered.
- ROB_DQ and RegRecycle_OUT default to 0 each cycle; they are pulses.
- Head eligible = ROB_Head_Valid & ROB_Head_Done & !ROB_DQ. The head is ignored in the cycle ROB_DQ is high, because the ROB has not yet advanced. Maximum throughput is one retire per 2 cycles.
- IDLE:
  - Eligible & Exception: go to HALT, Halt_OUT<=1, no retire, no RRAT change.
  - Eligible & !Exception & IsStore: go to ST_WAIT, Store_Commit<=1.
  - Eligible & !Exception & !IsStore: RETIRE action, stay in IDLE.
  - Otherwise: hold.
- ST_WAIT:
  - Store_Commit held at 1 until Store_Commit_Ack=1.
  - On the Ack cycle: Store_Commit<=0, RETIRE action, go to IDLE.
  - Head inputs are sampled on the Ack cycle.
- HALT: terminal until reset. Head ignored; Ack ignored.
- RETIRE action (same edge):
  - ROB_DQ<=1; Retired_UID<=ROB_Head_UID; Retired_Count<=Retired_Count+1, wrapping at 2^32.
  - If ROB_Head_RD!=0:
    - RRAT[RD]<={1, PhyRD}.
    - If old RRAT[RD].valid: RegRecycle_OUT<=1, RegRecycleID_OUT<=old phys.
    - If old valid=0 (first commit to that register since reset): no recycle.
  - If ROB_Head_RD==0: RRAT unchanged, no recycle (Rename never allocates for r0).
- Query port reads RRAT state before the edge. A write to the same entry is visible the cycle after the commit edge.
- Store_Commit_Ack while not in ST_WAIT is ignored.
- RegRecycleID_OUT holds its last value when RegRecycle_OUT=0.

Test Plan:
- Reset, then head {RD=5, PhyRD=12, !store, done} -> ROB_DQ pulses 1 cycle later; Retired_Count=1; RegRecycle_OUT stays 0; Query_Arch=5 gives Phys=12, Valid=1.
- Then head {RD=5, PhyRD=20} -> RegRecycle_OUT=1 with ID=12 for exactly one cycle; Query 5 gives 20; Retired_Count=2.
- Head held valid/done for 4 cycles with the ROB not advancing on its own -> ROB_DQ high every other cycle, never two consecutive cycles.
- Store head done, Ack asserted 3 cycles later -> Store_Commit high 3 cycles; ROB_DQ pulses after the Ack edge; RD=0 so no recycle.
- Exception head -> Halt_OUT=1; no ROB_DQ; later valid heads ignored; RESET clears Halt_OUT and all RRAT valid bits.
- RESET asserted while in ST_WAIT -> Store_Commit=0 next cycle; no ROB_DQ; Retired_Count=0.
